// File: rtl/line_bank_mcu.sv
// line_bank_mcu -- memory control unit between the GPIO control block, the
// address FSM, the convolver array and NB = N_CONV+K_LEN-1 line-bank memories.
//
// Load phase (i_load=1): pixels stream into rotating line banks, one image row
// per bank. Run phase (i_load=0): K_LEN-tall pixel windows are assembled for
// each convolver from the banks, results are written back in place, and the
// bank base rotates by N_CONV on each block change.
//
// Ports:
//   i_CLK, i_reset            clock, synchronous active-high reset
//   i_load                    1 = load phase, 0 = run phase
//   i_pix_valid, i_pix        pixel strobe / pixel (load phase only)
//   i_imgLength               pixels per row
//   i_rd_valid, i_raddr       window read request / column (run phase only)
//   i_res_valid, i_waddr, i_res  result strobe / column / lanes (run phase only)
//   i_chblk                   block change, advances the base bank
//   i_rdata                   bank read data, one cycle after o_raddr
//   o_we, o_waddr, o_wdata    registered bank write port
//   o_raddr                   bank read address (pass-through of i_raddr)
//   o_win, o_win_valid        assembled window, single-cycle valid pulse
//   o_base, o_rows, o_ovf     base bank, unconsumed rows, sticky overflow
module line_bank_mcu #(
    parameter int N_CONV      = 2,
    parameter int K_LEN       = 3,
    parameter int BITS_IMAGEN = 8,
    parameter int BITS_DATA   = 13,
    parameter int NB_ADDRESS  = 10,
    localparam int NB = N_CONV + K_LEN - 1,
    localparam int BW = $clog2(NB),
    localparam int RW = $clog2(NB + 1)
) (
    input  logic                                  i_CLK,
    input  logic                                  i_reset,
    input  logic                                  i_load,
    input  logic                                  i_pix_valid,
    input  logic [BITS_IMAGEN-1:0]                i_pix,
    input  logic [NB_ADDRESS-1:0]                 i_imgLength,
    input  logic                                  i_rd_valid,
    input  logic [NB_ADDRESS-1:0]                 i_raddr,
    input  logic                                  i_res_valid,
    input  logic [NB_ADDRESS-1:0]                 i_waddr,
    input  logic [N_CONV*BITS_DATA-1:0]           i_res,
    input  logic                                  i_chblk,
    input  logic [NB*BITS_DATA-1:0]               i_rdata,
    output logic [NB-1:0]                         o_we,
    output logic [NB_ADDRESS-1:0]                 o_waddr,
    output logic [NB*BITS_DATA-1:0]               o_wdata,
    output logic [NB_ADDRESS-1:0]                 o_raddr,
    output logic [N_CONV*K_LEN*BITS_IMAGEN-1:0]   o_win,
    output logic                                  o_win_valid,
    output logic [BW-1:0]                         o_base,
    output logic [RW-1:0]                         o_rows,
    output logic                                  o_ovf
);

    localparam int BD = BITS_DATA;
    localparam int BI = BITS_IMAGEN;
    localparam int NW = N_CONV * K_LEN * BI;
    localparam logic [BW:0]   NB_EXT     = (BW+1)'(NB);
    localparam logic [BW:0]   NCONV_EXT  = (BW+1)'(N_CONV);
    localparam logic [BW-1:0] LAST_BANK  = BW'(NB - 1);
    localparam logic [RW-1:0] NB_ROWS    = RW'(NB);
    localparam logic [RW-1:0] NCONV_ROWS = RW'(N_CONV);

    // (b + off) mod NB; off never exceeds NB-1 here, so one wrap suffices.
    function automatic logic [BW-1:0] bank_add(input logic [BW-1:0] b, input logic [BW:0] off);
        logic [BW:0] sum;
        sum = {1'b0, b} + off;
        if (sum >= NB_EXT) begin
            bank_add = BW'(sum - NB_EXT);
        end else begin
            bank_add = sum[BW-1:0];
        end
    endfunction

    logic [NB_ADDRESS-1:0] lcol_r;
    logic [BW-1:0]         lbank_r;
    logic [BW-1:0]         base_r;
    logic [RW-1:0]         rows_r;
    logic                  ovf_r;
    logic [NB-1:0]         we_r;
    logic [NB_ADDRESS-1:0] waddr_r;
    logic [NB*BD-1:0]      wdata_r;
    logic                  rd_pend_r;
    logic [BW-1:0]         rbase_r;
    logic [NW-1:0]         win_r;
    logic                  win_valid_r;

    logic                  pix_acc_s;
    logic                  res_acc_s;
    logic                  rd_acc_s;
    logic                  full_s;
    logic                  pix_write_s;
    logic                  row_done_s;
    logic [RW-1:0]         rows_inc_s;
    logic [RW-1:0]         rows_next_s;
    logic [NB*BD-1:0]      pix_wdata_s;
    logic [NB-1:0]         res_we_s;
    logic [NB*BD-1:0]      res_wdata_s;
    logic                  hit_s;
    logic [BD-1:0]         rbank_s [NB];
    logic [NW-1:0]         win_s;
    logic                  rdata_unused_s;

    assign pix_acc_s   = i_load & i_pix_valid;
    assign res_acc_s   = ~i_load & i_res_valid;
    assign rd_acc_s    = ~i_load & i_rd_valid;
    assign full_s      = (rows_r == NB_ROWS);
    assign pix_write_s = pix_acc_s & ~full_s;
    assign row_done_s  = pix_write_s & (lcol_r == (i_imgLength - NB_ADDRESS'(1)));
    // Cannot overflow: a row only completes while rows_r < NB.
    assign rows_inc_s  = rows_r + RW'(row_done_s);

    // Row count after a block change consumes N_CONV rows, saturating at zero.
    always_comb begin
        rows_next_s = rows_inc_s;
        if (i_chblk) begin
            if (rows_inc_s > NCONV_ROWS) begin
                rows_next_s = rows_inc_s - NCONV_ROWS;
            end else begin
                rows_next_s = '0;
            end
        end else begin
            rows_next_s = rows_inc_s;
        end
    end

    // Pixel write data: the zero-extended pixel on every bank lane.
    always_comb begin
        pix_wdata_s = '0;
        for (int b = 0; b < NB; b++) begin
            pix_wdata_s[b*BD +: BD] = BD'(i_pix);
        end
    end

    // Result routing: convolver lane c lands in bank (base+c) mod NB.
    always_comb begin
        res_we_s    = '0;
        res_wdata_s = '0;
        hit_s       = 1'b0;
        for (int c = 0; c < N_CONV; c++) begin
            for (int b = 0; b < NB; b++) begin
                hit_s = (bank_add(base_r, (BW+1)'(c)) == BW'(b));
                res_we_s[b] = res_we_s[b] | hit_s;
                res_wdata_s[b*BD +: BD] = hit_s ? i_res[c*BD +: BD] : res_wdata_s[b*BD +: BD];
            end
        end
    end

    // Window assembly from returning bank data using the base captured at request.
    always_comb begin
        win_s = '0;
        for (int b = 0; b < NB; b++) begin
            rbank_s[b] = i_rdata[b*BD +: BD];
        end
        for (int c = 0; c < N_CONV; c++) begin
            for (int k = 0; k < K_LEN; k++) begin
                win_s[(c*K_LEN + k)*BI +: BI] = rbank_s[bank_add(rbase_r, (BW+1)'(c + k))][BI-1:0];
            end
        end
    end

    // Bank words wider than a pixel only carry results; their upper bits never reach the window.
    assign rdata_unused_s = ^i_rdata;

    // Load counters, base rotation, row count and sticky overflow.
    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            lcol_r  <= '0;
            lbank_r <= '0;
            base_r  <= '0;
            rows_r  <= '0;
            ovf_r   <= 1'b0;
        end else begin
            if (pix_write_s) begin
                if (row_done_s) begin
                    lcol_r  <= '0;
                    lbank_r <= (lbank_r == LAST_BANK) ? '0 : lbank_r + BW'(1);
                end else begin
                    lcol_r  <= lcol_r + NB_ADDRESS'(1);
                end
            end
            if (pix_acc_s && full_s) begin
                ovf_r <= 1'b1;
            end
            if (i_chblk) begin
                base_r <= bank_add(base_r, NCONV_EXT);
            end
            rows_r <= rows_next_s;
        end
    end

    // Registered write port; pixel and result writes are exclusive by phase.
    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            we_r    <= '0;
            waddr_r <= '0;
            wdata_r <= '0;
        end else if (pix_write_s) begin
            we_r    <= NB'(1'b1) << lbank_r;
            waddr_r <= lcol_r;
            wdata_r <= pix_wdata_s;
        end else if (res_acc_s) begin
            we_r    <= res_we_s;
            waddr_r <= i_waddr;
            wdata_r <= res_wdata_s;
        end else begin
            we_r    <= '0;
        end
    end

    // Two-stage read pipeline: request/base capture, then window register.
    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            rd_pend_r   <= 1'b0;
            rbase_r     <= '0;
            win_r       <= '0;
            win_valid_r <= 1'b0;
        end else begin
            rd_pend_r   <= rd_acc_s;
            if (rd_acc_s) begin
                rbase_r <= base_r;
            end
            win_valid_r <= rd_pend_r;
            if (rd_pend_r) begin
                win_r <= win_s;
            end
        end
    end

    assign o_we        = we_r;
    assign o_waddr     = waddr_r;
    assign o_wdata     = wdata_r;
    assign o_raddr     = i_raddr;
    assign o_win       = win_r;
    assign o_win_valid = win_valid_r;
    assign o_base      = base_r;
    assign o_rows      = rows_r;
    assign o_ovf       = ovf_r;

endmodule
